// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and sizing for the sequential divider
//
// Purpose : FSM state encoding and default sizing constants used by the
//           divider top level and its testbench.
// Ports   : none (package)
package seq_divider_pkg;

   localparam int DEF_WIDTH = 3;
   localparam int DW        = 2 * DEF_WIDTH;
   localparam int CNT_W     = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring-division iteration
//
// Purpose : shifts the next dividend bit into the partial remainder and
//           conditionally subtracts the divisor, yielding one quotient bit.
// Ports   : r_i        partial remainder entering the step (always < divisor)
//           msb_i      dividend bit shifted in this step
//           divisor_i  denominator
//           r_o        partial remainder leaving the step (always < divisor)
//           q_o        quotient bit produced by this step
module div_step #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic             msb_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] r_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;

   always_comb begin
      shifted = {r_i, msb_i};
      if (shifted >= {1'b0, divisor_i}) begin
         // The true difference is below the divisor, so the low WIDTH
         // bits of a modular subtraction already hold it exactly.
         r_o = shifted[WIDTH-1:0] - divisor_i;
         q_o = 1'b1;
      end else begin
         r_o = shifted[WIDTH-1:0];
         q_o = 1'b0;
      end
   end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider with valid/ready handshakes
//
// Purpose : divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, one
//           quotient bit per clock. Divide-by-zero completes immediately.
// Ports   : clk, rst_n            clock, synchronous active-low reset
//           in_valid/in_ready     operand handshake
//           dividend, divisor     operands (unsigned)
//           out_valid/out_ready   result handshake
//           quotient, remainder   result, held stable until consumed
//           div_by_zero           divisor was zero for this result
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_by_zero
);

   localparam int QW = 2 * WIDTH;
   localparam int CW = $clog2(QW + 1);

   state_t           state_q, state_d;
   logic [QW-1:0]    dq_q, dq_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [QW-1:0]    quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] step_r;
   logic             step_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_i       (r_q),
      .msb_i     (dq_q[QW-1]),
      .divisor_i (div_q),
      .r_o       (step_r),
      .q_o       (step_q)
   );

   always_comb begin
      state_d = state_q;
      dq_d    = dq_q;
      r_d     = r_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dq_d  = dividend;
               div_d = divisor;
               r_d   = '0;
               cnt_d = '0;
               if (divisor == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = dividend[WIDTH-1:0];
                  dbz_d   = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            // dq doubles as the dividend shift register and the quotient
            // accumulator: each step consumes its MSB and fills its LSB.
            dq_d  = {dq_q[QW-2:0], step_q};
            r_d   = step_r;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(QW - 1)) begin
               state_d = DONE;
               quot_d  = {dq_q[QW-2:0], step_q};
               rem_d   = step_r;
               dbz_d   = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dq_q    <= '0;
         r_q     <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dq_q    <= dq_d;
         r_q     <= r_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;
   import seq_divider_pkg::*;

   localparam int W = DEF_WIDTH;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [W-1:0]  divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int q;
      int r;
      int dbz;
      int acc;
      bit seen;
   } exp_t;

   exp_t exp_q[$];

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input int n, input int d, input int acc);
      exp_t e;
      if (d == 0) begin
         e.q   = (1 << DW) - 1;
         e.r   = n % (1 << W);
         e.dbz = 1;
      end else begin
         e.q   = n / d;
         e.r   = n % d;
         e.dbz = 0;
      end
      e.acc  = acc;
      e.seen = 1'b0;
      return e;
   endfunction

   // Scoreboard: every cycle, compare the DUT against the arithmetic model.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         chk("in_ready", int'(in_ready), int'(exp_q.size() == 0));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 1, 0);
            end else begin
               chk("model_quotient", int'(quotient), exp_q[0].q);
               chk("model_remainder", int'(remainder), exp_q[0].r);
               chk("model_div_by_zero", int'(div_by_zero), exp_q[0].dbz);
               if (!exp_q[0].seen) begin
                  exp_q[0].seen = 1'b1;
                  chk("model_latency", cyc - exp_q[0].acc + 1,
                      (exp_q[0].dbz != 0) ? 1 : DW + 1);
               end
               if (out_ready) void'(exp_q.pop_front());
            end
         end else if (exp_q.size() != 0 && exp_q[0].seen) begin
            chk("out_valid_dropped", 0, 1);
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(int'(dividend), int'(divisor), cyc + 1));
      end
   end

   task automatic do_op(input int n, input int d, input int eq, input int er,
                        input int edbz, input int hold);
      int t;
      @(posedge clk);
      #1;
      dividend = DW'(n);
      divisor  = W'(d);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = DW'($urandom);
      divisor  = W'($urandom);
      t = 0;
      while (!out_valid && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!out_valid) begin
         chk("result_timeout", 0, 1);
         return;
      end
      chk("latency", t + 1, (edbz != 0) ? 1 : 7);
      chk("quotient", int'(quotient), eq);
      chk("remainder", int'(remainder), er);
      chk("div_by_zero", int'(div_by_zero), edbz);
      repeat (hold) begin
         @(posedge clk);
         #1;
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_quotient", int'(quotient), eq);
         chk("hold_remainder", int'(remainder), er);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("consumed_valid", int'(out_valid), 0);
      chk("consumed_in_ready", int'(in_ready), 1);
   endtask

   initial begin
      int e0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_quotient", int'(quotient), 0);
      chk("reset_remainder", int'(remainder), 0);
      chk("reset_div_by_zero", int'(div_by_zero), 0);
      rst_n = 1'b1;

      do_op(42, 6, 7, 0, 0, 0);
      do_op(63, 1, 63, 0, 0, 0);
      do_op(5, 7, 0, 5, 0, 0);
      do_op(0, 3, 0, 0, 0, 0);
      do_op(5, 0, 63, 5, 1, 0);
      do_op(6, 3, 2, 0, 0, 0);
      do_op(49, 7, 7, 0, 0, 5);

      // Reset in the middle of 40/3 discards the operation.
      @(posedge clk);
      #1;
      dividend = DW'(40);
      divisor  = W'(3);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_in_ready", int'(in_ready), 1);
      chk("midreset_quotient", int'(quotient), 0);
      chk("midreset_remainder", int'(remainder), 0);
      chk("midreset_div_by_zero", int'(div_by_zero), 0);
      repeat (10) @(posedge clk);
      do_op(40, 3, 13, 1, 0, 0);

      for (int a = 0; a < 8; a++) begin
         for (int b = 1; b < 8; b++) begin
            e0 = errors;
            do_op(a * b, b, a, 0, 0, 0);
            do_op(a * b + b - 1, b, a, b - 1, 0, 0);
            if (errors == e0) $display("sweep a=%0d b=%0d PASS", a, b);
         end
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
